pwm_capture: RTL
================

Name: pwm_capture

Overview:
- Receive-side counterpart to the PWM generator: measures an incoming PWM waveform and reports its high time, its period and its duty cycle in the same N-bit duty format the generator consumes.
- Used for loopback self-check of the generator output, and for reading external PWM sources such as servo signals and fan tachometers.
- Internal blocks: input synchronizer, edge detector, measurement counters, sequential restoring divider.

Parameters:
- N, 8, duty output width; full scale 2^N-1.
- M, 16, period/high counter width; sets the timeout limit of 2^M-1 ticks.
- SYNC_STAGES, 2, number of flops in the pwm_in synchronizer; minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
- ena  input  1  capture enable; 0 holds the block idle.
- pwm_in  input  1  asynchronous PWM input.
- high_ticks  output  M  clk cycles the input was high in the last complete period.
- period_ticks  output  M  clk cycles between the last two rising edges.
- duty  output  N  floor(high_ticks * 2^N / period_ticks), saturated to 2^N-1.
- valid  output  1  one-cycle pulse when high_ticks, period_ticks and duty update.
- timeout  output  1  sticky flag: no rising edge seen within 2^M-1 ticks.
- overrun  output  1  sticky flag: a measurement was dropped because the divider was busy.

Behaviour:
- Reset (rst=0, asynchronous):
  - Synchronizer flops, edge register, all counters and all outputs clear to 0.
  - FSM goes to IDLE and the divider to FREE.
- Input path:
  - pwm_in passes through SYNC_STAGES flops to give s_in.
  - A rising edge is s_in=1 with the previous s_in=0, detected at cycle E.
  - The pin-to-edge latency is SYNC_STAGES+1 cycles.
- FSM states:
  - IDLE: counters are held at 0. On a rising edge, go to MEASURE with period_cnt=1 and high_cnt=1.
  - MEASURE, each cycle with no rising edge:
    - period_cnt increments.
    - high_cnt increments when s_in=1.
  - MEASURE, on a rising edge:
    - Hand (high_cnt, period_cnt) to the divider.
    - Restart with period_cnt=1 and high_cnt=1.
    - Stay in MEASURE.
  - Timeout: if period_cnt reaches 2^M-1 in MEASURE with no edge, or IDLE persists for 2^M-1 cycles with ena=1:
    - Set timeout=1 and go to IDLE.
    - Set duty to 2^N-1 if s_in=1, else 0.
    - Set high_ticks and period_ticks to 0 and pulse valid.
    - The IDLE timeout repeats every 2^M-1 cycles.
- Divider:
  - Restoring, unsigned, one quotient bit per cycle, N iterations.
  - The dividend is high_cnt<<N, computed at M+N bits.
  - If the edge is at cycle E, iterations run E+1..E+N. At E+N+1, high_ticks, period_ticks and duty update together and valid=1 for exactly that cycle.
  - A quotient of 2^N or more saturates to 2^N-1.
- Overrun:
  - A handoff while the divider is busy (period < N+1 cycles) drops the new measurement.
  - overrun is set to 1; the in-progress division completes normally.
- Sticky flags:
  - timeout clears on the next valid that comes from a division.
  - overrun clears only on reset or on an ena falling edge.
- ena=0 (synchronous effect):
  - FSM goes to IDLE and any division in flight is aborted with no valid.
  - Outputs hold their values; the timeout counter does not run.
  - Capture restarts on the first rising edge after ena returns to 1.
- Simultaneous events: a rising edge in the same cycle that period_cnt hits 2^M-1 counts as an edge, so the measurement is taken and no timeout is raised.
- Reset mid-operation discards all state immediately; no valid is produced for the partial period.
- Outputs are registered.

Test Plan:
1. Steady PWM, period 100 and high 25, ena=1 → from the second period on, each valid gives high_ticks=25, period_ticks=100, duty=64; valid arrives N+1=9 cycles after each edge detect.
2. Period 10, high 3 → high_ticks=3, period_ticks=10, duty=76 (768/10 floor); period 256, high 255 → duty=255.
3. With M=8, drive pwm_in constant 1 after one rising edge → timeout=1 and duty=255 after 254 counts; then resume PWM with period 40, high 20 → duty=128 and timeout clears.
4. Period 5, high 2 (shorter than N+1) → overrun=1; every second measurement is dropped; each delivered result has duty=102.
5. Assert rst low mid-period, asynchronously between clock edges → all outputs read 0 immediately; after release, the first valid appears only after two new rising edges.
6. Drop ena during a division → no valid, outputs hold their old values, overrun clears; re-raise ena → normal capture resumes.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform.
// Reports high time and period in clk ticks, plus duty in the N-bit
// generator format: floor(high * 2^N / period), saturated to 2^N-1.
// Ports:
//   clk, rst (async, active low), ena (capture enable), pwm_in (async pin)
//   high_ticks, period_ticks [M-1:0] : last complete period measurement
//   duty [N-1:0]                     : duty of that measurement
//   valid                            : one-cycle pulse on output update
//   timeout                          : sticky, no rising edge in 2^M-1 ticks
//   overrun                          : sticky, measurement dropped (divider busy)
module pwm_capture #(
  parameter int unsigned N           = 8,
  parameter int unsigned M           = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         pwm_in,
  output logic [M-1:0] high_ticks,
  output logic [M-1:0] period_ticks,
  output logic [N-1:0] duty,
  output logic         valid,
  output logic         timeout,
  output logic         overrun
);

  localparam int unsigned CW        = $clog2(N + 1);
  localparam logic [M-1:0] CNT_MAX  = '1;
  localparam logic [M-1:0] IDLE_LAST = CNT_MAX - M'(1);
  localparam logic [N-1:0] DUTY_MAX = '1;

  typedef enum logic { IDLE, MEASURE } state_e;
  typedef enum logic { FREE, BUSY } div_e;

  state_e                 state_q, state_d;
  div_e                   div_q, div_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_prev_q, s_prev_d;
  logic                   ena_q, ena_d;
  logic [M-1:0]           period_cnt_q, period_cnt_d;
  logic [M-1:0]           high_cnt_q, high_cnt_d;
  logic [M-1:0]           idle_cnt_q, idle_cnt_d;
  logic [CW-1:0]          div_cnt_q, div_cnt_d;
  logic [M-1:0]           rem_q, rem_d;
  logic [N-1:0]           quo_q, quo_d;
  logic [M-1:0]           div_high_q, div_high_d;
  logic [M-1:0]           div_per_q, div_per_d;
  logic                   div_sat_q, div_sat_d;
  logic [M-1:0]           high_ticks_q, high_ticks_d;
  logic [M-1:0]           period_ticks_q, period_ticks_d;
  logic [N-1:0]           duty_q, duty_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;
  logic                   overrun_q, overrun_d;

  logic                   s_in;
  logic                   rise;
  logic [M:0]             rem_sh;
  logic                   sub_ok;
  logic [M-1:0]           rem_nx;
  logic [N-1:0]           quo_nx;
  logic                   handoff;
  logic                   to_event;

  assign s_in = sync_q[SYNC_STAGES-1];
  assign rise = s_in & ~s_prev_q;

  // One restoring-division step. The remainder starts at high_cnt, which is
  // exactly where the first M steps on the (high_cnt << N) dividend land when
  // high_cnt < period_cnt; the remaining N steps shift in the zero low bits.
  assign rem_sh = {rem_q, 1'b0};
  assign sub_ok = rem_sh >= {1'b0, div_per_q};
  assign rem_nx = sub_ok ? M'(rem_sh - {1'b0, div_per_q}) : M'(rem_sh);
  assign quo_nx = {quo_q[N-2:0], sub_ok};

  // Next-state: synchronizer, measurement FSM, divider and output registers.
  always_comb begin
    state_d        = state_q;
    div_d          = div_q;
    sync_d         = {sync_q[SYNC_STAGES-2:0], pwm_in};
    s_prev_d       = s_in;
    ena_d          = ena;
    period_cnt_d   = period_cnt_q;
    high_cnt_d     = high_cnt_q;
    idle_cnt_d     = idle_cnt_q;
    div_cnt_d      = div_cnt_q;
    rem_d          = rem_q;
    quo_d          = quo_q;
    div_high_d     = div_high_q;
    div_per_d      = div_per_q;
    div_sat_d      = div_sat_q;
    high_ticks_d   = high_ticks_q;
    period_ticks_d = period_ticks_q;
    duty_d         = duty_q;
    valid_d        = 1'b0;
    timeout_d      = timeout_q;
    overrun_d      = overrun_q;
    handoff        = 1'b0;
    to_event       = 1'b0;

    if (!ena) begin
      // Disabled: abort capture and division, outputs hold, idle timer frozen.
      state_d      = IDLE;
      div_d        = FREE;
      div_cnt_d    = '0;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      if (ena_q) overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d      = MEASURE;
            period_cnt_d = M'(1);
            high_cnt_d   = M'(1);
            idle_cnt_d   = '0;
          end else if (idle_cnt_q == IDLE_LAST) begin
            to_event   = 1'b1;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + M'(1);
          end
        end
        MEASURE: begin
          idle_cnt_d = '0;
          if (rise) begin
            // An edge on the last count still wins over the timeout.
            handoff      = 1'b1;
            period_cnt_d = M'(1);
            high_cnt_d   = M'(1);
          end else if (period_cnt_q == CNT_MAX) begin
            to_event     = 1'b1;
            state_d      = IDLE;
            period_cnt_d = '0;
            high_cnt_d   = '0;
          end else begin
            period_cnt_d = period_cnt_q + M'(1);
            if (s_in) high_cnt_d = high_cnt_q + M'(1);
          end
        end
        default: state_d = IDLE;
      endcase

      if (div_q == BUSY) begin
        rem_d     = rem_nx;
        quo_d     = quo_nx;
        div_cnt_d = div_cnt_q + CW'(1);
        if (div_cnt_q == CW'(N - 1)) begin
          div_d          = FREE;
          high_ticks_d   = div_high_q;
          period_ticks_d = div_per_q;
          duty_d         = div_sat_q ? DUTY_MAX : quo_nx;
          valid_d        = 1'b1;
          timeout_d      = 1'b0;
        end
        // A new measurement while dividing is dropped.
        if (handoff) overrun_d = 1'b1;
      end else if (handoff) begin
        div_d      = BUSY;
        div_cnt_d  = '0;
        div_sat_d  = high_cnt_q >= period_cnt_q;
        rem_d      = (high_cnt_q >= period_cnt_q) ? '0 : high_cnt_q;
        quo_d      = '0;
        div_high_d = high_cnt_q;
        div_per_d  = period_cnt_q;
      end

      if (to_event) begin
        timeout_d      = 1'b1;
        duty_d         = s_in ? DUTY_MAX : '0;
        high_ticks_d   = '0;
        period_ticks_d = '0;
        valid_d        = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      div_q          <= FREE;
      sync_q         <= '0;
      s_prev_q       <= 1'b0;
      ena_q          <= 1'b0;
      period_cnt_q   <= '0;
      high_cnt_q     <= '0;
      idle_cnt_q     <= '0;
      div_cnt_q      <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      div_high_q     <= '0;
      div_per_q      <= '0;
      div_sat_q      <= 1'b0;
      high_ticks_q   <= '0;
      period_ticks_q <= '0;
      duty_q         <= '0;
      valid_q        <= 1'b0;
      timeout_q      <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      div_q          <= div_d;
      sync_q         <= sync_d;
      s_prev_q       <= s_prev_d;
      ena_q          <= ena_d;
      period_cnt_q   <= period_cnt_d;
      high_cnt_q     <= high_cnt_d;
      idle_cnt_q     <= idle_cnt_d;
      div_cnt_q      <= div_cnt_d;
      rem_q          <= rem_d;
      quo_q          <= quo_d;
      div_high_q     <= div_high_d;
      div_per_q      <= div_per_d;
      div_sat_q      <= div_sat_d;
      high_ticks_q   <= high_ticks_d;
      period_ticks_q <= period_ticks_d;
      duty_q         <= duty_d;
      valid_q        <= valid_d;
      timeout_q      <= timeout_d;
      overrun_q      <= overrun_d;
    end
  end

  assign high_ticks   = high_ticks_q;
  assign period_ticks = period_ticks_q;
  assign duty         = duty_q;
  assign valid        = valid_q;
  assign timeout      = timeout_q;
  assign overrun      = overrun_q;

endmodule
